// File: rtl/iir_sample_sequencer.sv
// iir_sample_sequencer
// Sample-rate sequencer for an IIR filter core. It does the following:
//   - divides clk_i down to the sample tick;
//   - latches the newest upstream sample;
//   - launches one core calculation per tick;
//   - captures the core result into a held output.
// Sticky flags report overrun (tick while busy), timeout (core never
// answered) and underrun (no fresh sample at launch).
//
// Optional build: define IIR_SEQ_STATS_EN to add done_cnt_o and max_lat_o.
//
// Ports:
//   clk_i, rst_n_i            system clock, async active-low reset
//   sample_i, sample_valid_i  upstream sample stream
//   filt_start_o, filt_data_o launch strobe and operand to the core
//   filt_data_i, filt_valid_i core result
//   data_o, data_valid_o      held filtered output and update pulse
//   clear_i                   clears the sticky flags (and stats)
//   overrun_o, timeout_o, underrun_o  sticky status flags
//
// state | meaning
// IDLE  | no calculation in flight; the next tick launches one
// BUSY  | calculation launched; waiting for filt_valid_i or watchdog expiry
module iir_sample_sequencer #(
  parameter int DW      = 16,
  parameter int DIV     = 1024,
  parameter int TIMEOUT = 1000
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic signed [DW-1:0] sample_i,
  input  logic                 sample_valid_i,
  output logic                 filt_start_o,
  output logic signed [DW-1:0] filt_data_o,
  input  logic signed [DW-1:0] filt_data_i,
  input  logic                 filt_valid_i,
  output logic signed [DW-1:0] data_o,
  output logic                 data_valid_o,
  input  logic                 clear_i,
  output logic                 overrun_o,
  output logic                 timeout_o,
  output logic                 underrun_o
`ifdef IIR_SEQ_STATS_EN
  ,
  output logic [31:0]            done_cnt_o,
  output logic [$clog2(DIV)-1:0] max_lat_o
`endif
);

  localparam int CW = $clog2(DIV);
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
  localparam logic [WW-1:0] WD_LIMIT = WW'(TIMEOUT);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BUSY = 1'b1;

  logic [CW-1:0]        r_cnt;
  logic [WW-1:0]        r_wd;
  logic [0:0]           r_state;
  logic signed [DW-1:0] r_hold;
  logic                 r_fresh;
  logic                 r_start;
  logic signed [DW-1:0] r_fdata;
  logic signed [DW-1:0] r_data;
  logic                 r_dvalid;
  logic                 r_overrun;
  logic                 r_timeout;
  logic                 r_underrun;

  logic w_tick;
  logic w_busy;
  logic w_capture;
  logic w_launch;
  logic w_drop;
  logic w_timeout;
  logic w_underrun;

  assign w_tick     = (r_cnt == CNT_LAST);
  assign w_busy     = (r_state == S_BUSY);
  assign w_capture  = w_busy & filt_valid_i;
  // A result arriving on the tick frees the core in time for the next launch.
  assign w_launch   = w_tick & (~w_busy | filt_valid_i);
  assign w_drop     = w_busy & w_tick & ~filt_valid_i;
  // A result on the last allowed cycle still wins over the watchdog.
  assign w_timeout  = w_busy & ~filt_valid_i & (r_wd == WD_LIMIT);
  assign w_underrun = w_launch & ~r_fresh;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_cnt <= '0;
    end else if (w_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state    <= S_IDLE;
      r_wd       <= '0;
      r_hold     <= '0;
      r_fresh    <= 1'b0;
      r_start    <= 1'b0;
      r_fdata    <= '0;
      r_data     <= '0;
      r_dvalid   <= 1'b0;
      r_overrun  <= 1'b0;
      r_timeout  <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      r_start  <= w_launch;
      r_dvalid <= w_capture;

      // Launch reads the old hold value; a coincident sample stays fresh.
      if (w_launch) r_fdata <= r_hold;
      if (w_capture) r_data <= filt_data_i;

      if (sample_valid_i) begin
        r_hold  <= sample_i;
        r_fresh <= 1'b1;
      end else if (w_launch) begin
        r_fresh <= 1'b0;
      end

      if (w_launch) begin
        r_state <= S_BUSY;
      end else if (w_capture || w_timeout) begin
        r_state <= S_IDLE;
      end

      if (w_launch) begin
        r_wd <= '0;
      end else if (w_busy && (r_wd != WD_LIMIT)) begin
        r_wd <= r_wd + 1'b1;
      end

      // Set beats clear when both happen in the same cycle.
      r_overrun  <= (r_overrun  & ~clear_i) | w_drop;
      r_timeout  <= (r_timeout  & ~clear_i) | w_timeout;
      r_underrun <= (r_underrun & ~clear_i) | w_underrun;
    end
  end

  assign filt_start_o = r_start;
  assign filt_data_o  = r_fdata;
  assign data_o       = r_data;
  assign data_valid_o = r_dvalid;
  assign overrun_o    = r_overrun;
  assign timeout_o    = r_timeout;
  assign underrun_o   = r_underrun;

`ifdef IIR_SEQ_STATS_EN
  logic [31:0]   r_done_cnt;
  logic [CW-1:0] r_max_lat;
  logic [CW-1:0] w_lat;

  // Watchdog reads 0 on the start cycle, so at capture it equals the latency.
  assign w_lat = CW'(r_wd);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_done_cnt <= '0;
      r_max_lat  <= '0;
    end else if (clear_i) begin
      r_done_cnt <= '0;
      r_max_lat  <= '0;
    end else if (w_capture) begin
      r_done_cnt <= r_done_cnt + 32'd1;
      if (w_lat > r_max_lat) r_max_lat <= w_lat;
    end
  end

  assign done_cnt_o = r_done_cnt;
  assign max_lat_o  = r_max_lat;
`endif

endmodule

// File: tb/tb_iir_sample_sequencer.sv
module tb_iir_sample_sequencer;
  localparam int DW      = 16;
  localparam int DIV     = 8;
  localparam int TIMEOUT = 7;

  logic          clk_i = 1'b0;
  logic          rst_n_i = 1'b0;
  logic [DW-1:0] sample_i = '0;
  logic          sample_valid_i = 1'b0;
  logic          filt_start_o;
  logic [DW-1:0] filt_data_o;
  logic [DW-1:0] filt_data_i = '0;
  logic          filt_valid_i = 1'b0;
  logic [DW-1:0] data_o;
  logic          data_valid_o;
  logic          clear_i = 1'b0;
  logic          overrun_o;
  logic          timeout_o;
  logic          underrun_o;
`ifdef IIR_SEQ_STATS_EN
  logic [31:0]            done_cnt_o;
  logic [$clog2(DIV)-1:0] max_lat_o;
`endif

  iir_sample_sequencer #(.DW(DW), .DIV(DIV), .TIMEOUT(TIMEOUT)) dut (
    .clk_i          (clk_i),
    .rst_n_i        (rst_n_i),
    .sample_i       (sample_i),
    .sample_valid_i (sample_valid_i),
    .filt_start_o   (filt_start_o),
    .filt_data_o    (filt_data_o),
    .filt_data_i    (filt_data_i),
    .filt_valid_i   (filt_valid_i),
    .data_o         (data_o),
    .data_valid_o   (data_valid_o),
    .clear_i        (clear_i),
    .overrun_o      (overrun_o),
    .timeout_o      (timeout_o),
    .underrun_o     (underrun_o)
`ifdef IIR_SEQ_STATS_EN
    ,
    .done_cnt_o     (done_cnt_o),
    .max_lat_o      (max_lat_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  int errs   = 0;
  int checks = 0;

  // Reference model: time-based view of the sequencer.
  int            m_cyc;
  int            m_tstart;
  bit            m_busy;
  bit            m_fresh;
  logic [DW-1:0] m_hold;
  bit            e_start;
  logic [DW-1:0] e_fdata;
  logic [DW-1:0] e_data;
  bit            e_dv;
  bit            e_ovr;
  bit            e_tmo;
  bit            e_und;

  // Filter core model: answers core_lat cycles after start with operand+1.
  bit            core_act;
  int            core_rem;
  int            core_lat;
  logic [DW-1:0] core_in;

  int n_start;
  int n_dv;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_cyc = 0; m_tstart = 0; m_busy = 0; m_fresh = 0; m_hold = '0;
    e_start = 0; e_fdata = '0; e_data = '0; e_dv = 0;
    e_ovr = 0; e_tmo = 0; e_und = 0;
  endtask

  task automatic model_step();
    bit tick, cap, launch, tmo, ovr;
    tick   = (m_cyc % DIV) == (DIV - 1);
    cap    = m_busy && filt_valid_i;
    launch = tick && (!m_busy || cap);
    tmo    = m_busy && !filt_valid_i && ((m_cyc - m_tstart) == TIMEOUT);
    ovr    = m_busy && tick && !filt_valid_i;
    e_start = launch;
    if (launch) e_fdata = m_hold;
    e_dv = cap;
    if (cap) e_data = filt_data_i;
    e_ovr = (e_ovr && !clear_i) || ovr;
    e_tmo = (e_tmo && !clear_i) || tmo;
    e_und = (e_und && !clear_i) || (launch && !m_fresh);
    if (launch) m_fresh = 0;
    if (sample_valid_i) begin
      m_hold  = sample_i;
      m_fresh = 1;
    end
    if (launch) begin
      m_busy   = 1;
      m_tstart = m_cyc + 1;
    end else if (cap || tmo) begin
      m_busy = 0;
    end
    m_cyc++;
  endtask

  task automatic check_zero(input string pfx);
    chk({pfx, "_start"},    {31'd0, filt_start_o}, 32'd0);
    chk({pfx, "_fdata"},    {16'd0, filt_data_o},  32'd0);
    chk({pfx, "_data"},     {16'd0, data_o},       32'd0);
    chk({pfx, "_dvalid"},   {31'd0, data_valid_o}, 32'd0);
    chk({pfx, "_overrun"},  {31'd0, overrun_o},    32'd0);
    chk({pfx, "_timeout"},  {31'd0, timeout_o},    32'd0);
    chk({pfx, "_underrun"}, {31'd0, underrun_o},   32'd0);
  endtask

  task automatic cycle(input bit sv, input logic [DW-1:0] s, input bit clr, input bit spur);
    sample_valid_i = sv;
    sample_i       = s;
    clear_i        = clr;
    if (core_act && core_rem == 0) begin
      filt_valid_i = 1'b1;
      filt_data_i  = core_in + 16'd1;
      core_act     = 0;
    end else begin
      filt_valid_i = spur;
      filt_data_i  = 16'($urandom);
      if (core_act) core_rem--;
    end
    model_step();
    @(posedge clk_i);
    #1;
    chk($sformatf("start@%0d", m_cyc),    {31'd0, filt_start_o}, {31'd0, e_start});
    chk($sformatf("fdata@%0d", m_cyc),    {16'd0, filt_data_o},  {16'd0, e_fdata});
    chk($sformatf("data@%0d", m_cyc),     {16'd0, data_o},       {16'd0, e_data});
    chk($sformatf("dvalid@%0d", m_cyc),   {31'd0, data_valid_o}, {31'd0, e_dv});
    chk($sformatf("overrun@%0d", m_cyc),  {31'd0, overrun_o},    {31'd0, e_ovr});
    chk($sformatf("timeout@%0d", m_cyc),  {31'd0, timeout_o},    {31'd0, e_tmo});
    chk($sformatf("underrun@%0d", m_cyc), {31'd0, underrun_o},   {31'd0, e_und});
    if (filt_start_o) begin
      core_act = 1;
      core_rem = core_lat;
      core_in  = filt_data_o;
      n_start++;
    end
    if (data_valid_o) n_dv++;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: observed=expired expected=finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    bit found;
    core_act = 0; core_rem = 0; core_lat = 3; core_in = '0;
    model_reset();

    // Reset state.
    repeat (2) @(posedge clk_i);
    #1;
    check_zero("rst");
    #2 rst_n_i = 1'b1;

    // Basic launch/result: sample 100, core latency 3.
    for (int c = 0; c <= 14; c++) cycle(c == 2, 16'd100, 0, 0);
    chk("p1_data", {16'd0, data_o}, 32'd101);
    chk("p1_underrun", {31'd0, underrun_o}, 32'd0);

    // Second tick without a new sample reuses 100 and flags underrun.
    for (int c = 15; c <= 20; c++) cycle(0, 16'd0, 0, 0);
    chk("p2_fdata", {16'd0, filt_data_o}, 32'd100);
    chk("p2_underrun", {31'd0, underrun_o}, 32'd1);
    cycle(1, 16'd200, 0, 0);
    cycle(0, 16'd0, 1, 0);
    chk("p2_underrun_clr", {31'd0, underrun_o}, 32'd0);

    // Core latency 9: abandoned at watchdog 7, late result ignored.
    core_lat = 9;
    for (int c = 23; c <= 38; c++) cycle(0, 16'd0, 0, 0);
    chk("p3_timeout", {31'd0, timeout_o}, 32'd1);
    chk("p3_data_held", {16'd0, data_o}, 32'd101);

    // Core latency 10: tick while busy is dropped.
    core_lat = 10;
    cycle(0, 16'd0, 0, 0);
    n_start = 0;
    for (int c = 40; c <= 53; c++) cycle(0, 16'd0, 0, 0);
    chk("p4_overrun", {31'd0, overrun_o}, 32'd1);
    chk("p4_no_extra_start", n_start, 32'd0);
    cycle(1, 16'd300, 0, 0);

    // Core latency 7: result lands on the tick, capture and relaunch together.
    core_lat = 7;
    cycle(0, 16'd0, 1, 0);
    n_start = 0; n_dv = 0;
    for (int c = 56; c <= 72; c++) cycle(0, 16'd0, 0, 0);
    chk("p5_overrun", {31'd0, overrun_o}, 32'd0);
    chk("p5_timeout", {31'd0, timeout_o}, 32'd0);
    chk("p5_dv_count", n_dv, 32'd2);
    chk("p5_start_count", n_start, 32'd2);

    // Randomized traffic.
    for (int c = 0; c < 300; c++) begin
      core_lat = $urandom_range(1, 12);
      cycle($urandom_range(0, 3) == 0, 16'($urandom), $urandom_range(0, 19) == 0,
            $urandom_range(0, 29) == 0);
    end

    // Asynchronous reset while BUSY.
    core_lat = 6;
    found = 0;
    for (int c = 0; c < 20 && !found; c++) begin
      cycle(0, 16'd0, 0, 0);
      if (filt_start_o) found = 1;
    end
    chk("arst_busy_seen", {31'd0, found}, 32'd1);
    cycle(0, 16'd0, 0, 0);
    #2 rst_n_i = 1'b0;
    #1;
    check_zero("arst");
    core_act = 0; filt_valid_i = 1'b0; sample_valid_i = 1'b0; clear_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    check_zero("arst_hold");
    #2 rst_n_i = 1'b1;
    model_reset();
    for (int c = 0; c < DIV; c++) cycle(0, 16'd0, 0, 0);
    chk("post_rst_start", {31'd0, filt_start_o}, 32'd1);
    chk("post_rst_underrun", {31'd0, underrun_o}, 32'd1);
    for (int c = 0; c < 10; c++) cycle(0, 16'd0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
